// File: rtl/clock_divider_pkg.sv
// Purpose : shared constants and helpers for the power-of-two clock divider.
// Contents: default counter width, divided-period helper for consumers/benches.
// Config  : optional rising-edge strobes are enabled with CLOCK_DIVIDER_RISE_EN.
package clock_divider_pkg;

  // Default number of divided outputs (counter bits).
  localparam int CLOCK_DIVIDER_DEFAULT_WIDTH = 32;

  // Period of divided output bit i, in enabled clk cycles: 2^(i+1).
  // Returned 65 bits wide so bit 63 (period 2^64) is still representable.
  function automatic logic [64:0] div_period(input int unsigned i);
    div_period = 65'd1 << (i + 1);
  endfunction

endpackage

// File: rtl/clock_divider_rise.sv
// Purpose : per-bit registered rising-edge strobes for the divided-clock bus.
// Latency : strobe is registered alongside the counter, so it is high in the
//           same cycle the corresponding out bit first reads 1.
// Backpressure: none; ena=0 clears all strobes for that cycle.
// Ports   : clk, nrst (async active-low), ena, cur (counter now),
//           nxt (counter value being loaded), rise (one-cycle strobes).
module clock_divider_rise #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ena,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] rise
);

  // A bit rises when it is 0 now and 1 in the value about to be loaded.
  // On wrap to zero no bit goes 0->1, so every strobe is naturally 0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rise <= '0;
    end else if (ena) begin
      rise <= nxt & ~cur;
    end else begin
      rise <= '0;
    end
  end

endmodule

// File: rtl/clock_divider.sv
// Purpose : free-running WIDTH-bit counter; out[i] is clk divided by 2^(i+1).
// Latency : registered outputs; first increment visible after the first enabled
//           edge following reset release.
// Backpressure: none; ena=0 holds the count (phase preserved) and clears strobes.
// Ports   : clk, nrst (async active-low), ena (count enable), out (divided bus),
//           out_rise (rising-edge strobes, only with CLOCK_DIVIDER_RISE_EN).
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = CLOCK_DIVIDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ena,
`ifdef CLOCK_DIVIDER_RISE_EN
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_rise
`else
  output logic [WIDTH-1:0] out
`endif
);

  // Catch illegal widths at elaboration rather than building a broken counter.
  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("clock_divider: WIDTH must be in 1..64");
  end

  // Exactly WIDTH bits: carry-out is dropped so all-ones wraps to zero.
  logic [WIDTH-1:0] nxt;
  assign nxt = out + WIDTH'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out <= '0;
    end else if (ena) begin
      out <= nxt;
    end
  end

`ifdef CLOCK_DIVIDER_RISE_EN
  clock_divider_rise #(
    .WIDTH (WIDTH)
  ) u_rise (
    .clk  (clk),
    .nrst (nrst),
    .ena  (ena),
    .cur  (out),
    .nxt  (nxt),
    .rise (out_rise)
  );
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Purpose : self-checking bench for clock_divider (WIDTH=32 and WIDTH=4 copies).
// Ports   : none; drives clk/nrst/ena, checks out (and out_rise when enabled).
// Config  : out_rise checks compiled in only with CLOCK_DIVIDER_RISE_EN.
module tb_clock_divider;
  import clock_divider_pkg::*;

  logic        clk;
  logic        nrst;
  logic        ena;
  logic [31:0] out32;
  logic [3:0]  out4;
`ifdef CLOCK_DIVIDER_RISE_EN
  logic [31:0] rise32;
  logic [3:0]  rise4;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 0;

  clock_divider #(.WIDTH(32)) dut32 (
    .clk      (clk),
    .nrst     (nrst),
    .ena      (ena),
`ifdef CLOCK_DIVIDER_RISE_EN
    .out      (out32),
    .out_rise (rise32)
`else
    .out      (out32)
`endif
  );

  clock_divider #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .nrst     (nrst),
    .ena      (ena),
`ifdef CLOCK_DIVIDER_RISE_EN
    .out      (out4),
    .out_rise (rise4)
`else
    .out      (out4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: number of enabled edges since the last reset, and whether the
  // most recent edge advanced the count.
  longint unsigned cnt = 0;
  bit              adv = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt = 0;
      adv = 0;
    end else begin
      adv = ena;
      if (ena) cnt = cnt + 1;
    end
  end

  // out[i] is high during the second half of each 2^(i+1)-cycle period.
  function automatic logic [63:0] exp_out(longint unsigned c, int w);
    logic [63:0] r;
    logic [64:0] p;
    r = '0;
    for (int i = 0; i < w; i++) begin
      p = div_period(i);
      r[i] = (({1'b0, c} % p) >= (p >> 1));
    end
    return r;
  endfunction

  // out[i] rises exactly when the phase within its period hits the midpoint.
  function automatic logic [63:0] exp_rise(longint unsigned c, bit a, int w);
    logic [63:0] r;
    logic [64:0] p;
    r = '0;
    for (int i = 0; i < w; i++) begin
      p = div_period(i);
      r[i] = a && (({1'b0, c} % p) == (p >> 1));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      check("model_out32", {32'd0, out32}, exp_out(cnt, 32));
      check("model_out4",  {60'd0, out4},  exp_out(cnt, 4));
`ifdef CLOCK_DIVIDER_RISE_EN
      check("model_rise32", {32'd0, rise32}, exp_rise(cnt, adv, 32));
      check("model_rise4",  {60'd0, rise4},  exp_rise(cnt, adv, 4));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

`ifdef CLOCK_DIVIDER_RISE_EN
  logic [3:0] rise_tbl [1:8];
  initial begin
    rise_tbl[1] = 4'h1; rise_tbl[2] = 4'h2; rise_tbl[3] = 4'h1; rise_tbl[4] = 4'h4;
    rise_tbl[5] = 4'h1; rise_tbl[6] = 4'h2; rise_tbl[7] = 4'h1; rise_tbl[8] = 4'h8;
  end
`endif

  initial begin
    nrst = 1'b0;
    ena  = 1'b1;

    // Reset held for two edges with ena=1.
    tick();
    armed = 1;
    tick();
    check("rst_hold", {32'd0, out32}, 64'h0);
    #2 nrst = 1'b1;
    #1 check("rst_release", {32'd0, out32}, 64'h0);

    // 64 enabled cycles from reset: sequence, division, wrap, strobes.
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k <= 3) check("count_seq", {32'd0, out32}, 64'(k));
      if (k == 2) check("div_b1_hi", {63'd0, out32[1]}, 64'd1);
      if (k == 4) check("div_b1_lo", {63'd0, out32[1]}, 64'd0);
      if (k == 4) check("div_b2_hi", {63'd0, out32[2]}, 64'd1);
      if (k == 8) check("div_b2_lo", {63'd0, out32[2]}, 64'd0);
      if (k == 31) check("div_b5_pre", {63'd0, out32[5]}, 64'd0);
      if (k == 32) check("div_b5_rise", {63'd0, out32[5]}, 64'd1);
      if (k == 15) check("wrap4_f", {60'd0, out4}, 64'hF);
      if (k == 16) check("wrap4_0", {60'd0, out4}, 64'h0);
      if (k == 17) check("wrap4_1", {60'd0, out4}, 64'h1);
`ifdef CLOCK_DIVIDER_RISE_EN
      if (k <= 8) check("rise4_tbl", {60'd0, rise4}, {60'd0, rise_tbl[k]});
      if (k == 16) check("rise4_wrap", {60'd0, rise4}, 64'h0);
`endif
    end

    // Enable hold at 5.
    #2 nrst = 1'b0;
    tick();
    #2 nrst = 1'b1;
    repeat (5) tick();
    check("hold_pre", {32'd0, out32}, 64'h5);
    #2 ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_val", {32'd0, out32}, 64'h5);
`ifdef CLOCK_DIVIDER_RISE_EN
      check("hold_rise", {32'd0, rise32}, 64'h0);
`endif
    end
    #2 ena = 1'b1;
    tick();
    check("hold_resume", {32'd0, out32}, 64'h6);

    // Asynchronous reset mid-count at 0x1234.
    #2 nrst = 1'b0;
    tick();
    #2 nrst = 1'b1;
    repeat (32'h1234) tick();
    check("pre_async", {32'd0, out32}, 64'h1234);
    #2 nrst = 1'b0;
    #1 check("async_clr", {32'd0, out32}, 64'h0);
    tick();
    #2 nrst = 1'b1;
    tick();
    check("post_async_1", {32'd0, out32}, 64'h1);
    tick();
    check("post_async_2", {32'd0, out32}, 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
